// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding, fetch-side control
// bundle and the bubble convention used by the IF/ID and ID/EX registers.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // A flushed pipeline register holds the canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic imem_req;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
  } fetch_ctl_t;

  // Quiescent bundle: nothing fetched, both pipeline boundaries hold bubbles.
  localparam fetch_ctl_t CTL_IDLE = '{
    pc_en:       1'b0,
    imem_req:    1'b0,
    if_id_en:    1'b0,
    if_id_flush: 1'b1,
    id_ex_flush: 1'b1
  };

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC enable/next-PC and the IF/ID and ID/EX boundary
// controls from boot, redirect, load-use and imem wait-state conditions.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_cur,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  load_use_hazard,
  input  logic                  imem_ready,
  output logic                  pc_en,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            state_dbg,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  imem_wait_cnt,
  output logic [CNT_WIDTH-1:0]  redirect_cnt
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);

  fetch_state_e          state_q;
  logic [BOOT_W-1:0]     boot_q;
  logic [DATA_WIDTH-1:0] target_q;

  logic [DATA_WIDTH-1:0] pc_seq;
  fetch_ctl_t            ctl;
  logic                  stall_inc;
  logic                  wait_inc;
  logic                  redir_inc;

  assign pc_seq = pc_cur + DATA_WIDTH'(INSTR_BYTES);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    ctl       = CTL_IDLE;
    pc_next   = pc_seq;
    stall_inc = 1'b0;
    wait_inc  = 1'b0;
    redir_inc = 1'b0;
    case (state_q)
      ST_RUN: begin
        ctl.imem_req = 1'b1;
        wait_inc     = !imem_ready;
        if (redirect_valid) begin
          ctl.pc_en       = imem_ready;
          ctl.if_id_en    = 1'b1;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
          redir_inc       = 1'b1;
          if (imem_ready) begin
            pc_next = redirect_target;
          end
        end else if (load_use_hazard) begin
          // Hold PC and the ID instruction; only EX receives a bubble.
          ctl.pc_en       = 1'b0;
          ctl.if_id_en    = 1'b0;
          ctl.if_id_flush = 1'b0;
          ctl.id_ex_flush = 1'b1;
          stall_inc       = 1'b1;
        end else if (!imem_ready) begin
          ctl.pc_en       = 1'b0;
          ctl.if_id_en    = 1'b1;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b0;
        end else begin
          ctl.pc_en       = 1'b1;
          ctl.if_id_en    = 1'b1;
          ctl.if_id_flush = 1'b0;
          ctl.id_ex_flush = 1'b0;
        end
      end
      ST_REDIR: begin
        // EX and ID hold bubbles here, so redirect/hazard inputs are ignored.
        ctl.imem_req    = 1'b1;
        ctl.pc_en       = imem_ready;
        ctl.if_id_en    = 1'b1;
        ctl.if_id_flush = 1'b1;
        ctl.id_ex_flush = 1'b1;
        pc_next         = target_q;
        wait_inc        = !imem_ready;
      end
      default: begin
        // BOOT and the illegal encoding both present the idle bundle.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      boot_q   <= BOOT_LOAD;
      target_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (boot_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            boot_q <= boot_q - BOOT_W'(1);
          end
        end
        ST_RUN: begin
          if (redirect_valid && !imem_ready) begin
            target_q <= redirect_target;
            state_q  <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          if (imem_ready) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          boot_q  <= BOOT_LOAD;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_imem_wait_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (wait_inc),
    .count (imem_wait_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redir_inc),
    .count (redirect_cnt)
  );

  assign pc_en       = ctl.pc_en;
  assign imem_req    = ctl.imem_req;
  assign if_id_en    = ctl.if_id_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_flush = ctl.id_ex_flush;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a cycle-level reference model queues the
// expected outputs, a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  localparam int DW   = 32;
  localparam int BC   = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pc_cur = '0;
  logic          redirect_valid = 1'b0;
  logic [DW-1:0] redirect_target = '0;
  logic          load_use_hazard = 1'b0;
  logic          imem_ready = 1'b1;
  logic          pc_en;
  logic [DW-1:0] pc_next;
  logic          imem_req;
  logic          if_id_en;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic [1:0]    state_dbg;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] imem_wait_cnt;
  logic [CW-1:0] redirect_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(DW), .BOOT_CYCLES(BC), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .load_use_hazard (load_use_hazard),
    .imem_ready      (imem_ready),
    .pc_en           (pc_en),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .state_dbg       (state_dbg),
    .stall_cnt       (stall_cnt),
    .imem_wait_cnt   (imem_wait_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  typedef struct {
    int          cyc;
    bit          pc_en;
    logic [31:0] pc_next;
    bit          imem_req;
    bit          if_id_en;
    bit          if_id_flush;
    bit          id_ex_flush;
    int          st;
    int          stall;
    int          waits;
    int          redir;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: cycles since reset, a pending-redirect flag and plain
  // integer event counts, clipped to the counter range when compared.
  int          since_rst = 0;
  bit          pending   = 1'b0;
  logic [31:0] pend_tgt  = '0;
  int          n_stall   = 0;
  int          n_wait    = 0;
  int          n_redir   = 0;
  logic [31:0] pc        = '0;
  bit          known     = 1'b0;

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, c, act, req);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] tgt,
                      input bit luh, input bit rdy);
    exp_t e;
    int   d_stall = 0;
    int   d_wait  = 0;
    int   d_redir = 0;
    @(posedge clk);
    #1;
    rst             = r;
    redirect_valid  = rv;
    redirect_target = tgt;
    load_use_hazard = luh;
    imem_ready      = rdy;
    pc_cur          = pc;
    cyc++;

    e.cyc         = cyc;
    e.pc_next     = pc + 32'd4;
    e.pc_en       = 1'b0;
    e.imem_req    = 1'b0;
    e.if_id_en    = 1'b0;
    e.if_id_flush = 1'b1;
    e.id_ex_flush = 1'b1;
    if (since_rst < BC) begin
      e.st = 0;
    end else if (pending) begin
      e.st       = 2;
      e.imem_req = 1'b1;
      e.if_id_en = 1'b1;
      e.pc_en    = rdy;
      e.pc_next  = pend_tgt;
      if (!rdy) d_wait = 1;
    end else begin
      e.st       = 1;
      e.imem_req = 1'b1;
      if (!rdy) d_wait = 1;
      if (rv) begin
        e.if_id_en = 1'b1;
        e.pc_en    = rdy;
        if (rdy) e.pc_next = tgt;
        d_redir = 1;
      end else if (luh) begin
        e.if_id_flush = 1'b0;
        d_stall = 1;
      end else begin
        e.if_id_en    = 1'b1;
        e.pc_en       = rdy;
        e.if_id_flush = !rdy;
        e.id_ex_flush = 1'b0;
      end
    end
    e.stall = sat(n_stall);
    e.waits = sat(n_wait);
    e.redir = sat(n_redir);
    if (known) sb_q.push_back(e);

    if (e.pc_en) pc = e.pc_next;
    if (r) begin
      since_rst = 0;
      pending   = 1'b0;
      n_stall   = 0;
      n_wait    = 0;
      n_redir   = 0;
      known     = 1'b1;
    end else begin
      if (since_rst < 1000) since_rst++;
      n_stall += d_stall;
      n_wait  += d_wait;
      n_redir += d_redir;
      if (e.st == 2 && rdy) pending = 1'b0;
      if (e.st == 1 && rv && !rdy) begin
        pending  = 1'b1;
        pend_tgt = tgt;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pc_en",         e.cyc, 32'(pc_en),         32'(e.pc_en));
      check("pc_next",       e.cyc, pc_next,            e.pc_next);
      check("imem_req",      e.cyc, 32'(imem_req),      32'(e.imem_req));
      check("if_id_en",      e.cyc, 32'(if_id_en),      32'(e.if_id_en));
      check("if_id_flush",   e.cyc, 32'(if_id_flush),   32'(e.if_id_flush));
      check("id_ex_flush",   e.cyc, 32'(id_ex_flush),   32'(e.id_ex_flush));
      check("state_dbg",     e.cyc, 32'(state_dbg),     32'(e.st));
      check("stall_cnt",     e.cyc, 32'(stall_cnt),     32'(e.stall));
      check("imem_wait_cnt", e.cyc, 32'(imem_wait_cnt), 32'(e.waits));
      check("redirect_cnt",  e.cyc, 32'(redirect_cnt),  32'(e.redir));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          r;
    bit          rv;
    bit          luh;
    bit          rdy;
    logic [31:0] tgt;

    // Boot timing from PC 0 with imem always ready.
    pc = 32'h0;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);

    // Single-cycle load-use stall, then resume at 0x14.
    pc = 32'h10;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Redirect accepted with imem ready.
    pc = 32'h20;
    step(0, 1, 32'h100, 0, 1);
    step(0, 0, 0, 0, 1);

    // Redirect during an imem wait: parked in REDIR until ready.
    step(0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Stall counter saturation and PC wrap.
    repeat (CMAX + 2) step(0, 0, 0, 1, 1);
    pc = 32'hFFFF_FFFC;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Reset while a redirect target is latched.
    step(0, 1, 32'h300, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1);

    // Randomized traffic with occasional resets and PC wrap points.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 249) == 0);
      rv  = pending ? 1'b0 : ($urandom_range(0, 7) == 0);
      luh = pending ? 1'b0 : ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) == 0) pc = 32'hFFFF_FFF8;
      step(r, rv, tgt, luh, rdy);
    end

    repeat (2) @(posedge clk);
    check("sb_drain", cyc, 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the program counter and IF/ID boundary of the pipelined RISC-V core. Drives the PC register enable and next-PC value, the IF/ID enable/flush and the ID/EX flush. It resolves load-use stalls, EX-stage redirects (taken branch/jump) and instruction-memory wait states. It also provides saturating performance counters. It sits between the hazard detection logic, the EX branch unit, the instruction memory and the PC register.

Parameters:
DATA_WIDTH, 32, width of PC and redirect target
BOOT_CYCLES, 2, cycles held idle after reset before the first fetch (minimum 1)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
pc_cur  input  DATA_WIDTH  current PC register output
redirect_valid  input  1  EX resolved taken branch/jump this cycle
redirect_target  input  DATA_WIDTH  redirect destination
load_use_hazard  input  1  ID instruction depends on a load in EX
imem_ready  input  1  instruction for pc_cur is returned this cycle
pc_en  output  1  PC register enable
pc_next  output  DATA_WIDTH  PC register input
imem_req  output  1  fetch request for pc_cur
if_id_en  output  1  IF/ID register enable
if_id_flush  output  1  IF/ID loads a bubble (NOP)
id_ex_flush  output  1  ID/EX loads a bubble
state_dbg  output  2  current FSM state encoding
stall_cnt  output  CNT_WIDTH  load-use stall cycles, saturating
imem_wait_cnt  output  CNT_WIDTH  cycles in RUN/REDIR with imem_ready=0, saturating
redirect_cnt  output  CNT_WIDTH  accepted redirects, saturating

Behaviour:
- Reset: rst=1 at a clock edge moves the block to BOOT, loads the boot counter with BOOT_CYCLES-1, and clears the three perf counters and the latched target. Reset mid-operation aborts any state, including a pending redirect.
- Output grouping: all outputs are combinational from state and inputs. Counters and the latched target are registered.
- Default output values: pc_next = pc_cur + 4, modulo 2^DATA_WIDTH. Wrap from all-ones-minus-3 to 0 is allowed.
- State encoding: BOOT=0, RUN=1, REDIR=2. Encoding 3 is illegal and returns to BOOT on the next edge.
- BOOT outputs: pc_en=0, imem_req=0, if_id_en=0, if_id_flush=1, id_ex_flush=1. Inputs are ignored and no counters increment.
- BOOT transition: the boot counter decrements each cycle. When it reads 0, the next state is RUN, so the first imem_req occurs exactly BOOT_CYCLES cycles after rst deasserts.
- RUN: imem_req=1. Priority is top-down:
  1. redirect_valid: id_ex_flush=1, if_id_flush=1, redirect_cnt++.
     - If imem_ready=1: pc_en=1 and pc_next=redirect_target, stay in RUN.
     - If imem_ready=0: pc_en=0, latch redirect_target, go to REDIR.
  2. load_use_hazard: pc_en=0, if_id_en=0 (hold the ID instruction), if_id_flush=0, id_ex_flush=1, stall_cnt++. If imem_ready=0, imem_wait_cnt also increments.
  3. imem_ready=0: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_flush=0, imem_wait_cnt++.
  4. Otherwise: pc_en=1, pc_next=pc_cur+4, if_id_en=1, both flushes 0.
- REDIR: imem_req=1, if_id_flush=1, id_ex_flush=1, if_id_en=1, pc_next=latched target, pc_en=imem_ready.
  - imem_ready=1 returns to RUN.
  - imem_ready=0 increments imem_wait_cnt.
  - redirect_valid and load_use_hazard are ignored, since EX and ID hold bubbles. The bench asserts they are 0.
- Counters: saturate at all-ones and never wrap. A same-cycle increment on a saturated counter holds the value.
- Latency: a redirect accepted with imem_ready=1 takes effect at the next edge, so the redirect target is fetched one cycle later. A load-use stall costs exactly one cycle per asserted hazard cycle.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the state type/encodings (BOOT, RUN, REDIR)
  - INSTR_BYTES=4
  - the NOP/bubble convention shared with the pipeline registers
- One sub-module, sat_counter: parameterized width, synchronous active-high clear, increment enable, saturating. It is instantiated three times.

Test Plan:
1. Boot timing: BOOT_CYCLES=2, pc_cur=0, imem_ready=1, release rst at cycle 0 -> pc_en=0 and imem_req=0 for cycles 0-1; imem_req=1, pc_en=1, pc_next=4 at cycle 2; state_dbg goes 0,0,1.
2. Load-use stall: in RUN with pc_cur=0x10, pulse load_use_hazard for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle pc_next=0x14 with pc_en=1; stall_cnt=1.
3. Redirect with ready: pc_cur=0x20, redirect_valid=1, target=0x100, imem_ready=1 -> pc_en=1, pc_next=0x100, both flushes=1, redirect_cnt=1; the next cycle is normal RUN.
4. Redirect during imem wait: redirect_valid=1, target=0x200, imem_ready=0 for 3 cycles, then 1 -> state REDIR for 3 cycles with pc_en=0 and flushes=1; pc_en=1 and pc_next=0x200 on the ready cycle; imem_wait_cnt=3 counting the redirect cycle; back to RUN.
5. Saturation and wrap: CNT_WIDTH=2, hold load_use_hazard for 5 cycles -> stall_cnt=3 and held. pc_cur=0xFFFFFFFC in normal RUN -> pc_next=0.
6. Reset mid-REDIR: assert rst while in REDIR with a target latched -> next state BOOT, all counters 0; after boot, pc_next=pc_cur+4, not the stale target.
